// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor reload.
// Produces a near-50% clk_out waveform and a period-start tick strobe.
module clk_div_prog #(
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 5
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_in,
    output logic             clk_out,
    output logic             tick,
    output logic             upd_pend,
    output logic             running
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [DIV_W-1:0] DIV_RST_V =
        (DIV_RST == 0) ? DIV_W'(1) : DIV_W'(DIV_RST);

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] div_in_fix;
    logic [DIV_W:0]   half;
    logic [DIV_W:0]   cnt_inc;
    logic             wrap;

    // One extra bit keeps half and cnt+1 exact at the largest divisor.
    always_comb begin
        div_in_fix = (div_in == '0) ? DIV_W'(1) : div_in;
        wrap       = (cnt == div_act - DIV_W'(1));
        half       = ({1'b0, div_act} + (DIV_W+1)'(1)) >> 1;
        cnt_inc    = {1'b0, cnt} + (DIV_W+1)'(1);
    end

    assign running = (state == RUN);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            div_act  <= DIV_RST_V;
            div_nxt  <= DIV_RST_V;
            upd_pend <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt      <= '0;
                    upd_pend <= 1'b0;
                    if (div_load)
                        div_act <= div_in_fix;
                    if (en) begin
                        state   <= RUN;
                        clk_out <= 1'b1;
                        tick    <= 1'b1;
                    end else begin
                        clk_out <= 1'b0;
                        tick    <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        clk_out  <= 1'b0;
                        tick     <= 1'b0;
                        upd_pend <= 1'b0;
                        // A pending divisor is committed rather than lost on exit.
                        if (div_load)
                            div_act <= div_in_fix;
                        else if (upd_pend)
                            div_act <= div_nxt;
                    end else if (wrap) begin
                        cnt      <= '0;
                        tick     <= 1'b1;
                        clk_out  <= 1'b1;
                        upd_pend <= 1'b0;
                        if (div_load)
                            div_act <= div_in_fix;
                        else if (upd_pend)
                            div_act <= div_nxt;
                    end else begin
                        cnt     <= cnt_inc[DIV_W-1:0];
                        tick    <= 1'b0;
                        clk_out <= (cnt_inc < half);
                        if (div_load) begin
                            div_nxt  <= div_in_fix;
                            upd_pend <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a 16-bit default instance and a
// 4-bit instance with DIV_RST=0.
module tb_clk_div_prog;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0, ld_a = 1'b0;
    logic [15:0] din_a = '0;
    logic        en_b = 1'b0, ld_b = 1'b0;
    logic [3:0]  din_b = '0;
    logic        co_a, tk_a, up_a, rn_a;
    logic        co_b, tk_b, up_b, rn_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [3:0] v;
        string      nm;
    } item_t;

    item_t qa[$];
    item_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clk_div_prog dut_a (
        .clk_in  (clk),
        .rst     (rst),
        .en      (en_a),
        .div_load(ld_a),
        .div_in  (din_a),
        .clk_out (co_a),
        .tick    (tk_a),
        .upd_pend(up_a),
        .running (rn_a)
    );

    clk_div_prog #(.DIV_W(4), .DIV_RST(0)) dut_b (
        .clk_in  (clk),
        .rst     (rst),
        .en      (en_b),
        .div_load(ld_b),
        .div_in  (din_b),
        .clk_out (co_b),
        .tick    (tk_b),
        .upd_pend(up_b),
        .running (rn_b)
    );

    task automatic check(input string nm, input logic [3:0] got,
                         input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got {clk,tick,pend,run}=%b want %b",
                     nm, cyc, got, exp);
        end
    endtask

    // Expected outputs for phase p of an N-cycle period.
    function automatic logic [3:0] ex(input int n, input int p,
                                      input logic pend);
        logic c, t;
        c = (p < (n + 1) / 2) ? 1'b1 : 1'b0;
        t = (p == 0) ? 1'b1 : 1'b0;
        return {c, t, pend, 1'b1};
    endfunction

    always @(negedge clk) begin
        item_t it;
        while (qa.size() > 0 && qa[0].cyc <= cyc) begin
            it = qa.pop_front();
            if (it.cyc != cyc) check({it.nm, "_stale"}, 4'hx, it.v);
            else check(it.nm, {co_a, tk_a, up_a, rn_a}, it.v);
        end
        while (qb.size() > 0 && qb[0].cyc <= cyc) begin
            it = qb.pop_front();
            if (it.cyc != cyc) check({it.nm, "_stale"}, 4'hx, it.v);
            else check(it.nm, {co_b, tk_b, up_b, rn_b}, it.v);
        end
    end

    // Drive one cycle of inputs and queue the result due after the next edge.
    task automatic one(input bit b, input logic e, input logic ld,
                       input logic [15:0] d, input logic [3:0] exp,
                       input string nm);
        item_t it;
        it.cyc = cyc + 1;
        it.v   = exp;
        it.nm  = nm;
        if (b) begin
            en_b = e; ld_b = ld; din_b = d[3:0];
            qb.push_back(it);
        end else begin
            en_a = e; ld_a = ld; din_a = d;
            qa.push_back(it);
        end
        @(posedge clk);
        #1;
        ld_a = 1'b0;
        ld_b = 1'b0;
    endtask

    task automatic run(input bit b, input int n, input int start,
                       input int count, input logic pend, input string nm);
        for (int i = 0; i < count; i++)
            one(b, 1'b1, 1'b0, 16'd0, ex(n, (start + i) % n, pend), nm);
    endtask

    initial begin
        #23;
        check("rst_a", {co_a, tk_a, up_a, rn_a}, 4'b0000);
        check("rst_b", {co_b, tk_b, up_b, rn_b}, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Default divisor 5, then drop en mid-period.
        one(0, 1'b0, 1'b0, 16'd0, 4'b0000, "a_idle");
        run(0, 5, 0, 12, 1'b0, "a_n5");
        one(0, 1'b0, 1'b1, 16'd4, 4'b0000, "a_stop_mid");

        // Divisors programmed while idle.
        run(0, 4, 0, 8, 1'b0, "a_n4");
        one(0, 1'b0, 1'b1, 16'd1, 4'b0000, "a_ld1");
        run(0, 1, 0, 4, 1'b0, "a_n1");
        one(0, 1'b0, 1'b1, 16'd2, 4'b0000, "a_ld2");
        run(0, 2, 0, 6, 1'b0, "a_n2");

        // N=6 with load of 3 at cnt=2.
        one(0, 1'b0, 1'b1, 16'd6, 4'b0000, "a_ld6");
        run(0, 6, 0, 3, 1'b0, "a_n6");
        one(0, 1'b1, 1'b1, 16'd3, ex(6, 3, 1'b1), "a_ld3_run");
        run(0, 6, 4, 2, 1'b1, "a_n6_pend");
        run(0, 3, 0, 6, 1'b0, "a_n3");

        // N=8, loads of 10 then 7: last one wins.
        one(0, 1'b0, 1'b1, 16'd8, 4'b0000, "a_ld8");
        run(0, 8, 0, 2, 1'b0, "a_n8");
        one(0, 1'b1, 1'b1, 16'd10, ex(8, 2, 1'b1), "a_ld10");
        run(0, 8, 3, 1, 1'b1, "a_n8_pend");
        one(0, 1'b1, 1'b1, 16'd7, ex(8, 4, 1'b1), "a_ld7");
        run(0, 8, 5, 3, 1'b1, "a_n8_pend2");
        run(0, 7, 0, 8, 1'b0, "a_n7");

        // Divisor 0 maps to 1.
        one(0, 1'b1, 1'b1, 16'd0, ex(7, 1, 1'b1), "a_ld0");
        run(0, 7, 2, 5, 1'b1, "a_n7_pend");
        run(0, 1, 0, 4, 1'b0, "a_n0as1");
        one(0, 1'b0, 1'b0, 16'd0, 4'b0000, "a_stop");

        // 4-bit instance: reset divisor 0 behaves as 1, N=15, wrap-cycle load.
        one(1, 1'b0, 1'b0, 16'd0, 4'b0000, "b_idle");
        run(1, 1, 0, 3, 1'b0, "b_n1");
        one(1, 1'b1, 1'b1, 16'd15, ex(15, 0, 1'b0), "b_ld15_wrap");
        run(1, 15, 1, 14, 1'b0, "b_n15");
        one(1, 1'b1, 1'b1, 16'd4, ex(4, 0, 1'b0), "b_ld4_wrap");
        run(1, 4, 1, 7, 1'b0, "b_n4");
        one(1, 1'b0, 1'b0, 16'd0, 4'b0000, "b_stop");

        // Async reset at cnt=3 of N=7 with an update pending.
        one(0, 1'b0, 1'b1, 16'd7, 4'b0000, "a_ld7_idle");
        run(0, 7, 0, 2, 1'b0, "a_n7b");
        one(0, 1'b1, 1'b1, 16'd3, ex(7, 2, 1'b1), "a_ld3_pend");
        run(0, 7, 3, 1, 1'b1, "a_n7b_pend");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("a_async_rst", {co_a, tk_a, up_a, rn_a}, 4'b0000);
        one(0, 1'b1, 1'b0, 16'd0, 4'b0000, "a_in_rst");
        rst = 1'b0;
        one(0, 1'b0, 1'b0, 16'd0, 4'b0000, "a_post_rst");
        run(0, 5, 0, 11, 1'b0, "a_n5_after_rst");
        one(0, 1'b0, 1'b0, 16'd0, 4'b0000, "a_end");

        repeat (3) @(posedge clk);
        #1;
        check("q_drained", {2'b00, qa.size() == 0, qb.size() == 0}, 4'b0011);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable integer clock divider, successor to the fixed divide-by-5 clock divider. It produces a near-50%-duty divided clock-enable waveform (`clk_out`) and a one-cycle period-boundary strobe (`tick`) from `clk_in`. The divisor is parametrised in width and reloadable at run time. Updates are glitch-free, because a new divisor takes effect only at a period boundary. It sits between the system clock source and the APB timer and peripheral logic that need a slower time base.

## Interface
- `DIV_W`, 16 — width of the divisor.
- `DIV_RST`, 5 — divisor after reset (50 MHz → 10 MHz); 0 is treated as 1.
- `clk_in`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable.
- `div_load`  in  1  one-cycle request to load `div_in`.
- `div_in`  in  DIV_W  new divisor N; 0 is treated as 1.
- `clk_out`  out  1  divided waveform, registered.
- `tick`  out  1  one-cycle pulse at the start of each period, registered.
- `upd_pend`  out  1  a loaded divisor is waiting for a period boundary.
- `running`  out  1  the FSM is in RUN.

## Operation
- Registers:
  - `cnt[DIV_W-1:0]`
  - `div_act` (active N)
  - `div_nxt` (pending N)
  - `upd_pend`
  - state
  - `clk_out`
  - `tick`
- FSM with two states, IDLE and RUN.
- IDLE:
  - `cnt`=0, `clk_out`=0, `tick`=0.
  - `div_load` writes `div_act` directly; `upd_pend` stays 0.
  - Transition: if `en`=1, go to RUN with `cnt`<=0, `clk_out`<=1, `tick`<=1. The first period is therefore full length.
- RUN, `en`=1:
  - Define wrap = (`cnt` == `div_act`-1).
  - On wrap:
    - `cnt`<=0, `tick`<=1, `clk_out`<=1.
    - If `div_load` is active this cycle, `div_act`<=`div_in` and `upd_pend`<=0.
    - Else if `upd_pend`, `div_act`<=`div_nxt` and `upd_pend`<=0.
  - Otherwise:
    - `cnt`<=`cnt`+1, `tick`<=0.
    - `clk_out`<=(`cnt`+1 < H), where H = (`div_act`+1)>>1.
    - `div_load` sets `div_nxt`<=`div_in` and `upd_pend`<=1. A later load overwrites an earlier one; the last one wins.
- RUN, `en`=0: go to IDLE next edge with `cnt`<=0, `clk_out`<=0, `tick`<=0. A pending update is committed to `div_act` on this exit.
- Duty cycle for divisor N: high for ceil(N/2) cycles, low for floor(N/2) cycles.
  - N=1: `clk_out` is constantly 1 and `tick` is asserted every cycle.
  - N=2: 1 cycle high, 1 cycle low.
- Width rules:
  - Divisor 0 is mapped to 1 at capture, so `div_act` is never 0.
  - H is computed at DIV_W+1 bits, so N = 2^DIV_W-1 does not overflow.
  - `cnt` never exceeds `div_act`-1.
- `running` = (state == RUN).

## Timing
- Reset values: `clk_out`=0, `tick`=0, `upd_pend`=0, `running`=0, `cnt`=0, `div_act`=`DIV_RST` (or 1 if `DIV_RST`=0), state IDLE.
- Reset is asynchronous. Asserting `rst` mid-period forces all outputs to their reset values immediately, and any pending divisor is lost.
- Latency from `en` rising to `clk_out`/`tick` high: 1 edge.
- Period is exactly N `clk_in` cycles. `tick` is high in the first cycle of each period, coincident with the rising edge of `clk_out`.
- Divisor change while running:
  - The current period always completes with the old N.
  - The first period with the new N starts at the next `tick`.
  - There are no runt or stretched periods.
- A load on the wrap cycle applies to the period that starts at that same edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then `en`=1 with the default N=5 → `clk_out` repeats 1,1,1,0,0; `tick` every 5 cycles; first `tick` 1 cycle after `en`.
- Program N=4, 1 and 2 while in IDLE, then enable → patterns 1100, constant 1 with `tick` every cycle, and 10 respectively.
- Running at N=6, load N=3 at `cnt`=2 → `upd_pend`=1 until the next wrap; the remaining old period is 3 cycles; then period 3 with pattern 110; no glitches.
- Running at N=8, load 10 then 7 within one period → only 7 is applied, at the boundary; load `div_in`=0 → divide-by-1 behaviour.
- `DIV_W`=4, load N=15 → high 8, low 7, no overflow; load on the exact wrap cycle → the new N applies immediately.
- Assert `rst` at `cnt`=3 of N=7 with an update pending → outputs go to 0 asynchronously, `div_act`=`DIV_RST`, `upd_pend`=0; drop `en` mid-period → IDLE next edge, `clk_out`=0.
